alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequencing initiator for the 8-bit ALU. It accepts one arithmetic/logic instruction at a time over a valid/ready handshake, reads operands from an internal 16x8 register file, drives the ALU operand/op ports, captures result and carry/zero, and writes back result and flags. It sits between instruction decode and the combinational ALU in the BatPU2 core.

## Interface
- `NREGS`, default 16: register count; r0 is hardwired to zero.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  instruction offered.
- `req_ready`  out  1  controller can accept; high only in IDLE.
- `req_opcode`  in  4  2 ADD, 3 SUB, 4 NOR, 5 AND, 6 XOR, 7 RSH, 8 LDI, 9 ADI; others illegal.
- `req_dst`, `req_srca`, `req_srcb`  in  4 each  register indices.
- `req_imm`  in  8  immediate for LDI/ADI.
- `alu_a`, `alu_b`  out  8  ALU operands.
- `alu_op`  out  3  000 add, 001 sub, 010 nor, 011 and, 100 xor, 101 rsh.
- `alu_cin`  out  1  always 0.
- `alu_result`  in  8; `alu_cout`  in  1; `alu_zero`  in  1  ALU response, combinational.
- `done`  out  1  one-cycle pulse on writeback.
- `illegal`  out  1  one-cycle pulse on rejected opcode.
- `flag_z`, `flag_c`  out  1 each  architectural flags.
- `dbg_addr`  in  4; `dbg_data`  out  8  combinational register read; r0 reads 0.

## Operation
- States: IDLE, ISSUE, WB.
- IDLE: `req_ready`=1. On `req_valid`: a legal opcode latches opcode/dst/srca/srcb/imm and moves to ISSUE. An illegal opcode pulses `illegal` next cycle, stays in IDLE, and changes no state.
- ISSUE: drive ALU inputs.
  - ADD/SUB/NOR/AND/XOR: `alu_a`=R[srca], `alu_b`=R[srcb].
  - RSH: `alu_a`=R[srca], `alu_b`=0.
  - ADI: `alu_a`=R[srca], `alu_b`=imm, op add.
  - Capture `alu_result`, `alu_cout`, `alu_zero` into holding registers at the cycle end, then go to WB.
  - LDI bypasses the ALU: holds imm and goes to WB.
- WB: write result to R[dst] unless dst=0; pulse `done`; return to IDLE.
- Flags update in WB:
  - ADD/SUB/NOR/AND/XOR/ADI set `flag_z`=captured zero.
  - ADD/ADI set `flag_c`=captured cout.
  - SUB sets `flag_c`=~captured cout (carry = no borrow; 5-3 gives C=1, 3-5 gives C=0).
  - NOR/AND/XOR set `flag_c`=0.
  - RSH and LDI leave both flags unchanged.
  - With dst=0 the flags still update (compare idiom).
- Outside ISSUE, `alu_a`/`alu_b`/`alu_op` are driven 0.
- All arithmetic is 8-bit modulo; the register file is write-only from WB.

## Timing
- Accept to `done`: 2 cycles. Throughput: 1 instruction per 3 cycles.
- A written register is visible on `dbg_data` and to the next instruction's ISSUE in the cycle after WB.
- Reset values: state IDLE, all registers 0, `flag_z`=0, `flag_c`=0, `done`=0, `illegal`=0, ALU outputs 0, `req_ready`=1 from the first cycle after reset deasserts.
- Reset asserted in ISSUE or WB aborts the instruction: no register write, no flag change, no `done`.
- `req_valid` is ignored while `req_ready`=0; no buffering.

## Configuration
- `ALU_ISSUE_IMM_EN`
  - Defined: LDI and ADI are legal as described.
  - Undefined: opcodes 8 and 9 are illegal (pulse `illegal`), `req_imm` is unused, and the immediate path and latch are removed.

## Structure
- Shared package `batpu_pkg`: opcode enum (4-bit), ALU op enum (3-bit), register-index width constant, FSM state enum.
- One sub-module `batpu_regfile`: NREGS x 8, one sync write port, two async read ports plus the debug read port, r0 hardwired to 0.

## Test plan
- Reset, then LDI r1,5; LDI r2,3; SUB r3,r1,r2 -> `dbg_data`(r3)=2, C=1, Z=0; `done` 2 cycles after each accept.
- SUB r0,r2,r1 (3-5) -> r0 reads 0, C=0, Z=0; SUB r0,r1,r1 -> Z=1, C=1.
- LDI r4,0xFF; ADI r4,r4,1 -> r4=0x00, Z=1, C=1; then RSH r5,r1 -> r5=2, flags unchanged.
- Opcode 0xB with `req_valid` -> `illegal` pulse, `req_ready` stays 1, registers and flags unchanged.
- Assert `rst_n`=0 during WB of ADD r6 -> r6=0, flags 0, no `done`, IDLE next cycle.
- Without `ALU_ISSUE_IMM_EN`: LDI -> `illegal` pulse, r-file unchanged.

Source files
------------

// File: rtl/batpu_pkg.sv
// rtl/batpu_pkg.sv - shared opcode, ALU op and FSM state types for the BatPU2 ALU issue path
// LDI/ADI legality depends on ALU_ISSUE_IMM_EN.
package batpu_pkg;
  localparam int REG_AW = 4;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    OPC_ADD = 4'd2,
    OPC_SUB = 4'd3,
    OPC_NOR = 4'd4,
    OPC_AND = 4'd5,
    OPC_XOR = 4'd6,
    OPC_RSH = 4'd7,
    OPC_LDI = 4'd8,
    OPC_ADI = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOR = 3'b010,
    ALU_AND = 3'b011,
    ALU_XOR = 3'b100,
    ALU_RSH = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2
  } state_e;

  function automatic logic opcode_legal(input logic [3:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_NOR, OPC_AND, OPC_XOR, OPC_RSH: opcode_legal = 1'b1;
`ifdef ALU_ISSUE_IMM_EN
      OPC_LDI, OPC_ADI: opcode_legal = 1'b1;
`endif
      default: opcode_legal = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction request handshake between decode and the ALU issue controller
interface alu_issue_ctrl_if;
  import batpu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_opcode;
  logic [REG_AW-1:0] req_dst;
  logic [REG_AW-1:0] req_srca;
  logic [REG_AW-1:0] req_srcb;
  logic [DATA_W-1:0] req_imm;

  modport master (
    output req_valid, req_opcode, req_dst, req_srca, req_srcb, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_dst, req_srca, req_srcb, req_imm,
    output req_ready
  );
endinterface

// File: rtl/batpu_regfile.sv
// rtl/batpu_regfile.sv - NREGS x 8 register file, one sync write port, two async reads plus debug read
module batpu_regfile
  import batpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  // r0 is forced to zero on every read port regardless of array contents
  assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - IDLE/ISSUE/WB sequencer feeding the combinational 8-bit ALU
// Immediate instructions (LDI/ADI) and the immediate latch exist only with ALU_ISSUE_IMM_EN.
module alu_issue_ctrl
  import batpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   req,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero,
  output logic              done,
  output logic              illegal,
  output logic              flag_z,
  output logic              flag_c,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e            state;
  opcode_e           opc;
  logic [REG_AW-1:0] dst, srca, srcb;
`ifdef ALU_ISSUE_IMM_EN
  logic [DATA_W-1:0] imm;
`endif
  logic [DATA_W-1:0] res_q;
  logic              cout_q, zero_q;
  logic [DATA_W-1:0] rd_a, rd_b;

  batpu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == ST_WB),
    .waddr    (dst),
    .wdata    (res_q),
    .raddr_a  (srca),
    .raddr_b  (srcb),
    .dbg_addr (dbg_addr),
    .rdata_a  (rd_a),
    .rdata_b  (rd_b),
    .dbg_data (dbg_data)
  );

  assign req.req_ready = (state == ST_IDLE);
  assign alu_cin       = 1'b0;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (state == ST_ISSUE) begin
      case (opc)
        OPC_ADD: begin alu_a = rd_a; alu_b = rd_b; alu_op = ALU_ADD; end
        OPC_SUB: begin alu_a = rd_a; alu_b = rd_b; alu_op = ALU_SUB; end
        OPC_NOR: begin alu_a = rd_a; alu_b = rd_b; alu_op = ALU_NOR; end
        OPC_AND: begin alu_a = rd_a; alu_b = rd_b; alu_op = ALU_AND; end
        OPC_XOR: begin alu_a = rd_a; alu_b = rd_b; alu_op = ALU_XOR; end
        OPC_RSH: begin alu_a = rd_a; alu_op = ALU_RSH; end
`ifdef ALU_ISSUE_IMM_EN
        OPC_ADI: begin alu_a = rd_a; alu_b = imm; alu_op = ALU_ADD; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      opc     <= OPC_ADD;
      dst     <= '0;
      srca    <= '0;
      srcb    <= '0;
`ifdef ALU_ISSUE_IMM_EN
      imm     <= '0;
`endif
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req.req_valid) begin
            if (opcode_legal(req.req_opcode)) begin
              opc   <= opcode_e'(req.req_opcode);
              dst   <= req.req_dst;
              srca  <= req.req_srca;
              srcb  <= req.req_srcb;
`ifdef ALU_ISSUE_IMM_EN
              imm   <= req.req_imm;
`endif
              state <= ST_ISSUE;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          res_q  <= alu_result;
`ifdef ALU_ISSUE_IMM_EN
          if (opc == OPC_LDI) res_q <= imm;
`endif
          cout_q <= alu_cout;
          zero_q <= alu_zero;
          // done is high for the whole WB cycle, two cycles after accept
          done   <= 1'b1;
          state  <= ST_WB;
        end
        ST_WB: begin
          // ALU cout on SUB is a borrow; the architectural carry is its inverse
          case (opc)
            OPC_ADD: begin flag_z <= zero_q; flag_c <= cout_q;  end
            OPC_SUB: begin flag_z <= zero_q; flag_c <= ~cout_q; end
            OPC_NOR, OPC_AND, OPC_XOR: begin flag_z <= zero_q; flag_c <= 1'b0; end
`ifdef ALU_ISSUE_IMM_EN
            OPC_ADI: begin flag_z <= zero_q; flag_c <= cout_q;  end
`endif
            default: ;
          endcase
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with an ALU model and reference model
module tb_alu_issue_ctrl;
  logic       clk;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_result, dbg_data;
  logic [2:0] alu_op;
  logic       alu_cin, alu_cout, alu_zero;
  logic       done, illegal, flag_z, flag_c;
  logic [3:0] dbg_addr;

  int total = 0;
  int bad   = 0;
  int mr [16];
  int mz, mc;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.NREGS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .alu_zero   (alu_zero),
    .done       (done),
    .illegal    (illegal),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU: cout on subtract signals a borrow
  always_comb begin
    alu_result = 8'h00;
    alu_cout   = 1'b0;
    case (alu_op)
      3'b000: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      3'b001: begin alu_result = alu_a - alu_b; alu_cout = (alu_a < alu_b); end
      3'b010: alu_result = ~(alu_a | alu_b);
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = alu_a >> 1;
      default: ;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx, input int exp);
    dbg_addr = idx[3:0];
    #1;
    chk(tag, {24'h0, dbg_data}, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mr[i] = 0;
    mz = 0;
    mc = 0;
  endtask

  task automatic run_instr(input logic [3:0] opc, input logic [3:0] d, input logic [3:0] sa,
                           input logic [3:0] sb, input logic [7:0] im);
    int a, b, res, sum, eb, eop;
    bit legal, upd;
    a = mr[sa];
    b = mr[sb];
    legal = (opc >= 4'd2 && opc <= 4'd7);
`ifdef ALU_ISSUE_IMM_EN
    if (opc == 4'd8 || opc == 4'd9) legal = 1'b1;
`endif
    @(posedge clk); #1;
    chk("idle_ready", {31'h0, bus.req_ready}, 1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = opc;
    bus.req_dst    = d;
    bus.req_srca   = sa;
    bus.req_srcb   = sb;
    bus.req_imm    = im;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (!legal) begin
      chk("illegal_pulse", {31'h0, illegal}, 1);
      chk("illegal_ready", {31'h0, bus.req_ready}, 1);
      @(posedge clk); #1;
      chk("illegal_clear", {31'h0, illegal}, 0);
    end else begin
      chk("issue_ready", {31'h0, bus.req_ready}, 0);
      chk("issue_done", {31'h0, done}, 0);
      res = 0; upd = 1'b1; eb = b; eop = 0;
      case (opc)
        4'd2: begin sum = a + b; res = sum % 256; mc = (sum > 255); eop = 0; end
        4'd3: begin res = (a - b + 256) % 256; mc = (a >= b); eop = 1; end
        4'd4: begin res = (~(a | b)) & 255; mc = 0; eop = 2; end
        4'd5: begin res = a & b; mc = 0; eop = 3; end
        4'd6: begin res = a ^ b; mc = 0; eop = 4; end
        4'd7: begin res = a / 2; upd = 1'b0; eb = 0; eop = 5; end
        4'd8: begin res = im; upd = 1'b0; end
        default: begin sum = a + im; res = sum % 256; mc = (sum > 255); eb = im; eop = 0; end
      endcase
      if (upd) mz = (res == 0);
      if (opc != 4'd8) begin
        chk("issue_alu_a", {24'h0, alu_a}, a);
        chk("issue_alu_b", {24'h0, alu_b}, eb);
        chk("issue_alu_op", {29'h0, alu_op}, eop);
      end
      @(posedge clk); #1;
      chk("wb_done", {31'h0, done}, 1);
      chk("wb_alu_a_zero", {24'h0, alu_a}, 0);
      @(posedge clk); #1;
      chk("after_done", {31'h0, done}, 0);
      if (d != 4'd0) mr[d] = res;
    end
    chk("flag_z", {31'h0, flag_z}, mz);
    chk("flag_c", {31'h0, flag_c}, mc);
    chk_reg("dst_reg", d, mr[d]);
  endtask

  initial begin
    logic [3:0] ropc;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_dst = '0;
    bus.req_srca = '0; bus.req_srcb = '0; bus.req_imm = '0;
    dbg_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'h0, bus.req_ready}, 1);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_illegal", {31'h0, illegal}, 0);
    chk("rst_flag_z", {31'h0, flag_z}, 0);
    chk("rst_flag_c", {31'h0, flag_c}, 0);
    chk("rst_alu_a", {24'h0, alu_a}, 0);
    chk("rst_alu_b", {24'h0, alu_b}, 0);
    chk("rst_alu_op", {29'h0, alu_op}, 0);
    chk("rst_alu_cin", {31'h0, alu_cin}, 0);
    for (int i = 0; i < 16; i++) chk_reg("rst_reg", i, 0);

`ifdef ALU_ISSUE_IMM_EN
    run_instr(4'd8, 4'd1, 4'd0, 4'd0, 8'd5);
    run_instr(4'd8, 4'd2, 4'd0, 4'd0, 8'd3);
    run_instr(4'd3, 4'd3, 4'd1, 4'd2, 8'd0);
    chk_reg("sub_5_3", 3, 2);
    chk("sub_5_3_c", {31'h0, flag_c}, 1);
    chk("sub_5_3_z", {31'h0, flag_z}, 0);
    run_instr(4'd3, 4'd0, 4'd2, 4'd1, 8'd0);
    chk_reg("r0_zero", 0, 0);
    chk("sub_3_5_c", {31'h0, flag_c}, 0);
    run_instr(4'd3, 4'd0, 4'd1, 4'd1, 8'd0);
    chk("cmp_eq_z", {31'h0, flag_z}, 1);
    chk("cmp_eq_c", {31'h0, flag_c}, 1);
    run_instr(4'd8, 4'd4, 4'd0, 4'd0, 8'hFF);
    run_instr(4'd9, 4'd4, 4'd4, 4'd0, 8'd1);
    chk_reg("adi_wrap", 4, 0);
    chk("adi_wrap_c", {31'h0, flag_c}, 1);
    run_instr(4'd7, 4'd5, 4'd1, 4'd0, 8'd0);
    chk_reg("rsh_5", 5, 2);
    chk("rsh_keeps_z", {31'h0, flag_z}, 1);
`else
    run_instr(4'd8, 4'd1, 4'd0, 4'd0, 8'd5);
    chk_reg("ldi_disabled", 1, 0);
    run_instr(4'd9, 4'd2, 4'd0, 4'd0, 8'd7);
    run_instr(4'd4, 4'd1, 4'd0, 4'd0, 8'd0);
    chk_reg("nor_zero", 1, 8'hFF);
    run_instr(4'd2, 4'd2, 4'd1, 4'd1, 8'd0);
    chk_reg("add_ff_ff", 2, 8'hFE);
    chk("add_ff_ff_c", {31'h0, flag_c}, 1);
    run_instr(4'd3, 4'd3, 4'd2, 4'd1, 8'd0);
    chk_reg("sub_borrow", 3, 8'hFF);
    chk("sub_borrow_c", {31'h0, flag_c}, 0);
    run_instr(4'd3, 4'd0, 4'd1, 4'd1, 8'd0);
    chk("cmp_eq_z", {31'h0, flag_z}, 1);
    chk("cmp_eq_c", {31'h0, flag_c}, 1);
    run_instr(4'd7, 4'd5, 4'd1, 4'd0, 8'd0);
    chk_reg("rsh_ff", 5, 8'h7F);
    chk("rsh_keeps_z", {31'h0, flag_z}, 1);
`endif
    run_instr(4'hB, 4'd6, 4'd1, 4'd2, 8'd0);

    // reset landing in WB of ADD r6 aborts the write
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_opcode = 4'd2; bus.req_dst = 4'd6;
    bus.req_srca = 4'd1; bus.req_srcb = 4'd2;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("abort_ready", {31'h0, bus.req_ready}, 1);
    chk("abort_done", {31'h0, done}, 0);
    chk("abort_flag_z", {31'h0, flag_z}, 0);
    chk("abort_flag_c", {31'h0, flag_c}, 0);
    chk_reg("abort_r6", 6, 0);
    @(posedge clk); #1;
    chk("abort_no_late_done", {31'h0, done}, 0);

    run_instr(4'd4, 4'd1, 4'd0, 4'd0, 8'd0);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) ropc = 4'($urandom_range(0, 15));
      else ropc = 4'($urandom_range(2, 9));
      run_instr(ropc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 16; i++) chk_reg("final_reg", i, mr[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
